// File: rtl/vga_timing_gen_pkg.sv
// Shared constants, phase encoding and helpers for the VGA raster timing generator.
package vga_timing_pkg;

    function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // 640x480@60 defaults
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned H_TOTAL_DEF  = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL_DEF  = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FPO = 2'd1,
        PH_SYN = 2'd2,
        PH_BPO = 2'd3
    } phase_t;

    // Phase of a counter value given the exclusive end of the active, porch and sync regions.
    function automatic phase_t phase_of(input logic [CNT_W-1:0] cnt,
                                        input logic [CNT_W-1:0] act_end,
                                        input logic [CNT_W-1:0] fp_end,
                                        input logic [CNT_W-1:0] syn_end);
        phase_t ph;
        if (cnt < act_end)
            ph = PH_ACT;
        else if (cnt < fp_end)
            ph = PH_FPO;
        else if (cnt < syn_end)
            ph = PH_SYN;
        else
            ph = PH_BPO;
        return ph;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Enable-gated shift register; depth 0 degenerates to a wire.
module sync_delay_line #(
    parameter int unsigned      WIDTH = 1,
    parameter int unsigned      DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = clk ^ rst_n ^ en;
            assign dout      = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Advance one stage per enable; stage 0 takes the live input.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < int'(DEPTH); i++)
                        stage[i] <= INIT;
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++)
                        stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v scan counters, phase FSMs, aligned sync/blank and frame ticks.
//
// Phase FSM (one instance on h, one on v):
//   state  | meaning
//   PH_ACT | visible region
//   PH_FPO | front porch
//   PH_SYN | sync pulse
//   PH_BPO | back porch
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned PIX_DIV    = 2,
    parameter int unsigned SYNC_DELAY = 2,
    parameter logic        HS_POL     = 1'b0,
    parameter logic        VS_POL     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pix_en,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             display_on,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n,
    output logic             frame_tick,
    output logic             vblank_tick
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(line_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(line_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_FP_END   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYN_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_FP_END   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYN_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(PIX_DIV - 1);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] h, h_nxt;
    logic [CNT_W-1:0] v, v_nxt;
    phase_t           h_ph, h_ph_nxt;
    phase_t           v_ph, v_ph_nxt;
    logic             h_wrap, v_wrap;
    logic             hs_raw, vs_raw;
    logic [2:0]       dly_out;

    assign pix_en = (div == DIV_LAST);
    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);

    // Pixel divider: free-running count that restarts on each strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else if (pix_en)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    // Scan position for the next strobe; the last pixel of the frame folds straight to (0,0).
    always_comb begin
        h_nxt = h;
        v_nxt = v;
        if (pix_en) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = v_wrap ? '0 : v + 1'b1;
            end else begin
                h_nxt = h + 1'b1;
            end
        end
    end

    // Phase transitions follow the counter value being loaded on the same strobe.
    always_comb begin
        h_ph_nxt = h_ph;
        v_ph_nxt = v_ph;
        if (pix_en) begin
            h_ph_nxt = phase_of(h_nxt, H_ACT_END, H_FP_END, H_SYN_END);
            v_ph_nxt = phase_of(v_nxt, V_ACT_END, V_FP_END, V_SYN_END);
        end
    end

    // Counter and phase state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h    <= '0;
            v    <= '0;
            h_ph <= PH_ACT;
            v_ph <= PH_ACT;
        end else begin
            h    <= h_nxt;
            v    <= v_nxt;
            h_ph <= h_ph_nxt;
            v_ph <= v_ph_nxt;
        end
    end

    assign X           = h;
    assign Y           = v;
    assign display_on  = (h_ph == PH_ACT) && (v_ph == PH_ACT);
    assign hs_raw      = (h_ph == PH_SYN) ? HS_POL : ~HS_POL;
    assign vs_raw      = (v_ph == PH_SYN) ? VS_POL : ~VS_POL;
    assign frame_tick  = pix_en && h_wrap && v_wrap;
    assign vblank_tick = pix_en && (h == H_ACT_LAST) && (v == V_ACT_LAST);

    // Sync and blank trail the scan position to match the renderer's RGB pipeline.
    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (SYNC_DELAY),
        .INIT  ({~HS_POL, ~VS_POL, 1'b0})
    ) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .din   ({hs_raw, vs_raw, display_on}),
        .dout  (dly_out)
    );

    assign hsync   = dly_out[2];
    assign vsync   = dly_out[1];
    assign blank_n = dly_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameterisations checked every cycle against an arithmetic raster model,
// plus directed edge/period checks and an asynchronous mid-frame reset.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI-1:0]       pe, don, hso, vso, blo, fto, vto;
    logic [NI-1:0][15:0] xo, yo;

    // 0: defaults
    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[0]), .X(xo[0]), .Y(yo[0]), .display_on(don[0]),
        .hsync(hso[0]), .vsync(vso[0]), .blank_n(blo[0]), .frame_tick(fto[0]), .vblank_tick(vto[0]));

    // 1: default line, short frame, no sync delay
    vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_DELAY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[1]), .X(xo[1]), .Y(yo[1]), .display_on(don[1]),
        .hsync(hso[1]), .vsync(vso[1]), .blank_n(blo[1]), .frame_tick(fto[1]), .vblank_tick(vto[1]));

    // 2: one clk per pixel, positive sync polarity
    vga_timing_gen #(.V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2), .PIX_DIV(1), .SYNC_DELAY(0),
                     .HS_POL(1'b1), .VS_POL(1'b1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[2]), .X(xo[2]), .Y(yo[2]), .display_on(don[2]),
        .hsync(hso[2]), .vsync(vso[2]), .blank_n(blo[2]), .frame_tick(fto[2]), .vblank_tick(vto[2]));

    // 3: tiny raster for multi-frame tick checks
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(5), .V_FP(1), .V_SYNC(2),
                     .V_BP(2), .PIX_DIV(3), .SYNC_DELAY(3), .VS_POL(1'b1)) u_sm (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[3]), .X(xo[3]), .Y(yo[3]), .display_on(don[3]),
        .hsync(hso[3]), .vsync(vso[3]), .blank_n(blo[3]), .frame_tick(fto[3]), .vblank_tick(vto[3]));

    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, dv, dl; logic hp, vp; } cfg_t;
    typedef struct packed { logic pe; logic [15:0] x; logic [15:0] y; logic don, hs, vs, bl, ft, vt; } obs_t;
    typedef struct { int c; int x; int y; } ev_t;

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        c = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 2, 1'b0, 1'b0};
        case (i)
            1: begin c.va = 4; c.vf = 2; c.vs = 2; c.vb = 2; c.dl = 0; end
            2: begin c.va = 4; c.vf = 2; c.vs = 2; c.vb = 2; c.dl = 0; c.dv = 1; c.hp = 1'b1; c.vp = 1'b1; end
            3: begin c.ha = 8; c.hf = 2; c.hs = 3; c.hb = 2; c.va = 5; c.vf = 1; c.vs = 2; c.vb = 2;
                     c.dv = 3; c.dl = 3; c.vp = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // Expected outputs after n post-reset clk edges: n/dv pixels have elapsed in raster order.
    function automatic obs_t model(input cfg_t c, input int n);
        obs_t e;
        int ht, vtot, p, px, py, q, qx, qy;
        ht   = c.ha + c.hf + c.hs + c.hb;
        vtot = c.va + c.vf + c.vs + c.vb;
        p    = n / c.dv;
        px   = p % ht;
        py   = (p / ht) % vtot;
        e.pe  = ((n % c.dv) == c.dv - 1);
        e.x   = 16'(px);
        e.y   = 16'(py);
        e.don = (px < c.ha) && (py < c.va);
        e.ft  = e.pe && (px == ht - 1) && (py == vtot - 1);
        e.vt  = e.pe && (px == c.ha - 1) && (py == c.va - 1);
        e.bl  = 1'b0;
        e.hs  = ~c.hp;
        e.vs  = ~c.vp;
        if (p >= c.dl) begin
            q  = p - c.dl;
            qx = q % ht;
            qy = (q / ht) % vtot;
            e.bl = (qx < c.ha) && (qy < c.va);
            if (qx >= c.ha + c.hf && qx < c.ha + c.hf + c.hs) e.hs = c.hp;
            if (qy >= c.va + c.vf && qy < c.va + c.vf + c.vs) e.vs = c.vp;
        end
        return e;
    endfunction

    function automatic int evf(input ev_t q[$], input int k, input int field);
        if (k >= q.size()) return -1;
        case (field)
            0:       return q[k].c;
            1:       return q[k].x;
            default: return q[k].y;
        endcase
    endfunction

    int n = 0;
    int vectors = 0;
    int miscompares = 0;
    int nprint = 0;
    logic mon_on = 1'b0;
    logic [NI-1:0] pdon, phs, pvs, pbl;
    logic [15:0]   px2;
    ev_t q_def_don[$], q_def_bl[$], q_def_hs[$];
    ev_t q_d0_hsf[$], q_d0_hsr[$], q_d0_vsf[$], q_d0_vsr[$], q_d0_ft[$];
    ev_t q_p1_hsr[$], q_p1_hsf[$], q_p1_wrap[$];
    ev_t q_sm_ft[$], q_sm_vt[$];

    // Post-reset clk edge count, the model's only time base.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic step();
        obs_t a, e;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            a = {pe[i], xo[i], yo[i], don[i], hso[i], vso[i], blo[i], fto[i], vto[i]};
            e = model(cfg_of(i), n);
            vectors++;
            if (a !== e) begin
                miscompares++;
                if (nprint < 25)
                    $display("FAIL model_dut%0d n=%0d: got pe=%b x=%0d y=%0d don=%b hs=%b vs=%b bl=%b ft=%b vt=%b, expected pe=%b x=%0d y=%0d don=%b hs=%b vs=%b bl=%b ft=%b vt=%b",
                             i, n, a.pe, a.x, a.y, a.don, a.hs, a.vs, a.bl, a.ft, a.vt,
                             e.pe, e.x, e.y, e.don, e.hs, e.vs, e.bl, e.ft, e.vt);
                nprint++;
            end
        end
        if (mon_on) begin
            if (pdon[0] && !don[0]) q_def_don.push_back('{n, int'(xo[0]), int'(yo[0])});
            if (pbl[0]  && !blo[0]) q_def_bl.push_back('{n, int'(xo[0]), int'(yo[0])});
            if (phs[0]  && !hso[0]) q_def_hs.push_back('{n, int'(xo[0]), int'(yo[0])});
            if (phs[1]  && !hso[1]) q_d0_hsf.push_back('{n, int'(xo[1]), int'(yo[1])});
            if (!phs[1] &&  hso[1]) q_d0_hsr.push_back('{n, int'(xo[1]), int'(yo[1])});
            if (pvs[1]  && !vso[1]) q_d0_vsf.push_back('{n, int'(xo[1]), int'(yo[1])});
            if (!pvs[1] &&  vso[1]) q_d0_vsr.push_back('{n, int'(xo[1]), int'(yo[1])});
            if (fto[1])             q_d0_ft.push_back('{n, int'(xo[1]), int'(yo[1])});
            if (!phs[2] &&  hso[2]) q_p1_hsr.push_back('{n, int'(xo[2]), int'(yo[2])});
            if (phs[2]  && !hso[2]) q_p1_hsf.push_back('{n, int'(xo[2]), int'(yo[2])});
            if (xo[2] == 16'd0 && px2 != 16'd0) q_p1_wrap.push_back('{n, int'(xo[2]), int'(yo[2])});
            if (fto[3])             q_sm_ft.push_back('{n, int'(xo[3]), int'(yo[3])});
            if (vto[3])             q_sm_vt.push_back('{n, int'(xo[3]), int'(yo[3])});
        end
        pdon = don;
        phs  = hso;
        pvs  = vso;
        pbl  = blo;
        px2  = xo[2];
    endtask

    initial begin
        int cnt;
        int guard;
        rst_n = 1'b0;
        repeat (3) step();

        chk("rst_x",          int'(xo[0]),  0);
        chk("rst_y",          int'(yo[0]),  0);
        chk("rst_display_on", int'(don[0]), 1);
        chk("rst_blank_n",    int'(blo[0]), 0);
        chk("rst_hsync",      int'(hso[0]), 1);
        chk("rst_vsync",      int'(vso[0]), 1);
        chk("rst_pix_en",     int'(pe[0]),  0);
        chk("rst_frame_tick", int'(fto[0]), 0);
        chk("rst_vblank_tick",int'(vto[0]), 0);
        chk("rst_p1_pix_en",  int'(pe[2]),  1);
        chk("rst_p1_hsync",   int'(hso[2]), 0);
        chk("rst_p1_vsync",   int'(vso[2]), 0);

        rst_n  = 1'b1;
        mon_on = 1'b1;
        step();
        chk("first_pix_en",   int'(pe[0]), 1);
        chk("x_at_first_pix", int'(xo[0]), 0);
        step();
        chk("x_after_strobe", int'(xo[0]), 1);

        repeat (34000) step();
        mon_on = 1'b0;

        chk("def_don_fall_x",    evf(q_def_don, 0, 1), 640);
        chk("def_don_fall_y",    evf(q_def_don, 0, 2), 0);
        chk("def_don_fall_clk",  evf(q_def_don, 0, 0), 1280);
        chk("def_blank_lag_clks", evf(q_def_bl, 0, 0) - evf(q_def_don, 0, 0), 4);
        chk("def_hs_fall_x",     evf(q_def_hs, 0, 1), 658);

        chk("d0_hs_fall_x",      evf(q_d0_hsf, 0, 1), 656);
        chk("d0_hs_low_clks",    evf(q_d0_hsr, 0, 0) - evf(q_d0_hsf, 0, 0), 192);
        chk("d0_vs_fall_y",      evf(q_d0_vsf, 0, 2), 6);
        chk("d0_vs_fall_x",      evf(q_d0_vsf, 0, 1), 0);
        chk("d0_vs_low_clks",    evf(q_d0_vsr, 0, 0) - evf(q_d0_vsf, 0, 0), 3200);
        chk("d0_frame_clks",     evf(q_d0_ft, 1, 0) - evf(q_d0_ft, 0, 0), 16000);
        chk("d0_ft_x",           evf(q_d0_ft, 0, 1), 799);
        chk("d0_ft_y",           evf(q_d0_ft, 0, 2), 9);

        chk("p1_hs_rise_x",      evf(q_p1_hsr, 0, 1), 656);
        chk("p1_hs_fall_x",      evf(q_p1_hsf, 0, 1), 752);
        chk("p1_hs_high_clks",   evf(q_p1_hsf, 0, 0) - evf(q_p1_hsr, 0, 0), 96);
        chk("p1_line_clks",      evf(q_p1_wrap, 1, 0) - evf(q_p1_wrap, 0, 0), 800);

        cnt = 0;
        foreach (q_sm_ft[k]) if (q_sm_ft[k].c <= 1350) cnt++;
        chk("sm_ft_in_3_frames", cnt, 3);
        chk("sm_first_ft_clk",   evf(q_sm_ft, 0, 0), 449);
        chk("sm_ft_spacing_1",   evf(q_sm_ft, 1, 0) - evf(q_sm_ft, 0, 0), 450);
        chk("sm_ft_spacing_2",   evf(q_sm_ft, 2, 0) - evf(q_sm_ft, 1, 0), 450);
        chk("sm_ft_x",           evf(q_sm_ft, 0, 1), 14);
        chk("sm_ft_y",           evf(q_sm_ft, 0, 2), 9);
        chk("sm_vt_x",           evf(q_sm_vt, 0, 1), 7);
        chk("sm_vt_y",           evf(q_sm_vt, 0, 2), 4);
        chk("sm_vt_spacing",     evf(q_sm_vt, 1, 0) - evf(q_sm_vt, 0, 0), 450);

        guard = 0;
        while (xo[0] != 16'd400 && guard < 2000) begin
            step();
            guard++;
        end
        chk("reach_x400",          int'(xo[0]), 400);
        chk("pre_reset_y_nonzero", int'(yo[0] != 16'd0), 1);

        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_x",       int'(xo[0]),  0);
        chk("async_rst_y",       int'(yo[0]),  0);
        chk("async_rst_don",     int'(don[0]), 1);
        chk("async_rst_blank_n", int'(blo[0]), 0);
        chk("async_rst_hsync",   int'(hso[0]), 1);
        chk("async_rst_vsync",   int'(vso[0]), 1);
        chk("async_rst_pix_en",  int'(pe[0]),  0);
        chk("async_rst_sm_pe",   int'(pe[3]),  0);
        chk("async_rst_p1_pe",   int'(pe[2]),  1);

        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("restart_x",      int'(xo[0]), 0);
        chk("restart_y",      int'(yo[0]), 0);
        chk("restart_pix_en", int'(pe[0]), 1);
        step();
        chk("restart_x_step", int'(xo[0]), 1);
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 VGA output path. It divides the system clock down to a pixel strobe and walks horizontal and vertical counters through active, front-porch, sync and back-porch phases. It drives the `X`, `Y` and `display_on` scan position consumed by the image renderer, plus hsync, vsync and blank. The sync and blank outputs are delayed so they line up with the renderer's registered, ROM-latency RGB. It also emits per-frame ticks that replace the free-running game and animation clocks.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `PIX_DIV`, 2, clk cycles per pixel; legal range ≥1
- `SYNC_DELAY`, 2, pixel periods of delay on `hsync`/`vsync`/`blank_n`; legal range 0..7
- `HS_POL`, 0, asserted level of hsync
- `VS_POL`, 0, asserted level of vsync

Ports:
- `clk` in 1: system clock, single clock domain
- `rst_n` in 1: asynchronous, active-low reset
- `pix_en` out 1: one-clk pixel strobe
- `X` out 16: horizontal counter, 0..H_TOTAL-1
- `Y` out 16: vertical counter, 0..V_TOTAL-1
- `display_on` out 1: (X,Y) inside the active area, undelayed
- `hsync` out 1: delayed, polarity per `HS_POL`
- `vsync` out 1: delayed, polarity per `VS_POL`
- `blank_n` out 1: delayed copy of `display_on`
- `frame_tick` out 1: one-clk pulse at the last pixel of the frame
- `vblank_tick` out 1: one-clk pulse at the last active pixel of the frame

## Operation
- `H_TOTAL` = sum of the H parameters (800). `V_TOTAL` = sum of the V parameters (525). All counters are 16 bit unsigned.
- Divider `div` counts 0..PIX_DIV-1 and wraps. `pix_en` = (div == PIX_DIV-1). With PIX_DIV=1, `pix_en` is constantly 1 out of reset.
- On `pix_en`:
  - h increments. At H_TOTAL-1, h wraps to 0 and v increments.
  - At v == V_TOTAL-1 together with h == H_TOTAL-1, v wraps to 0.
- Counters hold between strobes. `X` = h and `Y` = v directly.
- Horizontal phase FSM, decoded from h: H_ACT (h < H_ACTIVE) -> H_FPO -> H_SYN -> H_BPO -> H_ACT. The vertical FSM is identical on v, using the V parameters.
- `display_on` = H_ACT && V_ACT.
- Raw hsync is asserted in H_SYN and raw vsync in V_SYN. The asserted level is the POL parameter; the idle level is its inverse.
- Raw hsync, raw vsync and `display_on` pass through a SYNC_DELAY-stage shift register that advances only on `pix_en`.
  - SYNC_DELAY=0 is a pure combinational pass-through.
- `frame_tick` = pix_en && h==H_TOTAL-1 && v==V_TOTAL-1.
- `vblank_tick` = pix_en && h==H_ACTIVE-1 && v==V_ACTIVE-1.
- There are no inputs besides clk and rst_n, so no simultaneous-event cases exist beyond the h/v double wrap. That wrap resolves to (0,0) on a single strobe.

## Timing
- Reset values:
  - div=0, `X`=0, `Y`=0, `display_on`=1 (decode of 0,0).
  - `blank_n`=0, `hsync`=~HS_POL, `vsync`=~VS_POL.
  - `pix_en`=0 unless PIX_DIV=1.
  - `frame_tick`=0, `vblank_tick`=0.
  - All delay stages are cleared to the blank/idle values.
- Reset is asserted asynchronously. Release is sampled on the next clk rising edge. Reset mid-frame restarts at (0,0) with no partial-line completion.
- First `pix_en` occurs PIX_DIV-1 clks after the first post-release edge. X becomes 1 on that edge.
- `hsync`/`vsync`/`blank_n` lag the `X`/`Y` decode by exactly SYNC_DELAY pixel periods, i.e. SYNC_DELAY*PIX_DIV clks.
- Line period = H_TOTAL*PIX_DIV clks (1600). Frame period = H_TOTAL*V_TOTAL*PIX_DIV clks (840000).
- Tick pulses are exactly 1 clk wide, with one of each per frame.

## Structure
- Package `vga_timing_pkg`:
  - 640x480@60 default constants.
  - Phase encoding, ACT/FPO/SYN/BPO, as a 2-bit typedef.
  - H_TOTAL/V_TOTAL derivation.
- Sub-module `sync_delay_line`, parameterised on width and depth, with a shift-enable input. It is instantiated once, 3 bits wide, for hsync, vsync and blank.

## Test plan
- Release reset, defaults -> first `pix_en` at clk 1; `X` steps 0..799 and wraps with `Y`: 0->1; `display_on` falls at X=640.
- Defaults, SYNC_DELAY=0 -> `hsync` low for exactly 96 pixels starting at X=656; `vsync` low for lines 490..491; measured frame = 840000 clks.
- SYNC_DELAY=2 -> `blank_n` edges trail the `display_on` edges by exactly 4 clks; hsync falls at X=658.
- Run 3 frames -> `frame_tick` seen 3 times, 840000 clks apart, at (799,524); `vblank_tick` at (639,479) each frame.
- Assert `rst_n` low asynchronously at (400,200) -> outputs reach their reset values without a clk edge; after release the scan restarts at (0,0).
- PIX_DIV=1, HS_POL=1 -> `pix_en` constantly high; `hsync` high only during X=656..751; line = 800 clks.
